// File: rtl/demux_rr_scheduler_if.sv
// Handshake and select bundle between the producer, the scheduler and the
// 4-way demux datapath. The master side drives the producer beat and the
// destination status; the slave side is the scheduler.
interface demux_rr_scheduler_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       dest_en;
   logic [3:0]       dest_ready;
   logic [1:0]       sel;
   logic [WIDTH-1:0] out_data;
   logic [3:0]       out_valid;
   logic             busy;

   modport master (
      output in_data, in_valid, dest_en, dest_ready,
      input  in_ready, sel, out_data, out_valid, busy
   );

   modport slave (
      input  in_data, in_valid, dest_en, dest_ready,
      output in_ready, sel, out_data, out_valid, busy
   );
endinterface

// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler owning the select lines of a 1-to-4 demux.
// Destinations are granted in bursts of up to BURST beats. A burst is cut
// short when its destination is disabled, and it stalls (without
// re-arbitrating) while the producer or the destination is not ready.
module demux_rr_scheduler #(
   parameter int WIDTH = 1,
   parameter int BURST = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   demux_rr_scheduler_if.slave  bus
);
   localparam int            CW        = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_XFER = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      sel_q, sel_d;
   logic [1:0]      last_grant_q, last_grant_d;
   logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

   logic [3:0]      eligible_s;
   logic            win_s;
   logic [1:0]      winner_s;
   logic [1:0]      cand_s;
   logic            in_ready_s;
   logic [3:0]      out_valid_s;
   logic [WIDTH-1:0] data_s;

   assign eligible_s = bus.dest_en & bus.dest_ready;

   // Round-robin search from last_grant+1 up to last_grant+4; scanning
   // downwards lets the nearest eligible candidate overwrite farther ones.
   always_comb begin
      win_s    = 1'b0;
      winner_s = last_grant_q;
      cand_s   = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         cand_s   = last_grant_q + 2'(k);
         win_s    = win_s | eligible_s[cand_s];
         winner_s = eligible_s[cand_s] ? cand_s : winner_s;
      end
   end

   // Next-state, grant bookkeeping and handshake outputs.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      in_ready_s   = 1'b0;
      out_valid_s  = 4'b0000;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               state_d = ST_ARB;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARB: begin
            if (win_s) begin
               sel_d      = winner_s;
               beat_cnt_d = {CW{1'b0}};
               state_d    = ST_XFER;
            end else if (bus.in_valid) begin
               state_d = ST_ARB;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_XFER: begin
            if (bus.dest_en[sel_q]) begin
               in_ready_s = bus.dest_ready[sel_q];
               if (bus.in_valid && in_ready_s) begin
                  out_valid_s[sel_q] = 1'b1;
                  if (beat_cnt_q == LAST_BEAT) begin
                     last_grant_d = sel_q;
                     state_d      = ST_ARB;
                  end else begin
                     beat_cnt_d = beat_cnt_q + CW'(1);
                  end
               end else begin
                  state_d = ST_XFER;
               end
            end else begin
               // Destination withdrawn: end the burst without a transfer.
               last_grant_d = sel_q;
               state_d      = ST_ARB;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and grant registers; reset makes the first search start at 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         sel_q        <= 2'd0;
         last_grant_q <= 2'd3;
         beat_cnt_q   <= {CW{1'b0}};
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

   assign data_s        = bus.in_data;
   assign bus.out_data  = data_s;
   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.sel       = sel_q;
   assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Directed bench for demux_rr_scheduler with a grant-level reference model.
module tb_demux_rr_scheduler;
   localparam int WIDTH = 8;
   localparam int BURST = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   demux_rr_scheduler_if #(.WIDTH(WIDTH)) bus();

   demux_rr_scheduler #(.WIDTH(WIDTH), .BURST(BURST)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 = waiting, 1 = choosing, 2 = owner holds the stream.
   int m_phase = 0;
   int m_owner = 0;
   int m_prev  = 3;
   int m_beats = 0;
   int m_cyc   = 0;
   int m_log_dest[$];
   int m_log_cyc[$];

   function automatic int rr_pick(input int prev, input logic [3:0] el);
      int pick;
      pick = -1;
      for (int k = 1; k <= 4; k++) begin
         if (pick < 0 && el[(prev + k) % 4]) pick = (prev + k) % 4;
      end
      return pick;
   endfunction

   // Model advance on every clock; async reset mirrors the pin.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_phase <= 0; m_owner <= 0; m_prev <= 3; m_beats <= 0; m_cyc <= 0;
      end else begin
         m_cyc <= m_cyc + 1;
         if (m_phase == 0) begin
            if (bus.in_valid) m_phase <= 1;
         end else if (m_phase == 1) begin
            if (rr_pick(m_prev, bus.dest_en & bus.dest_ready) >= 0) begin
               m_owner <= rr_pick(m_prev, bus.dest_en & bus.dest_ready);
               m_beats <= 0;
               m_phase <= 2;
            end else if (!bus.in_valid) begin
               m_phase <= 0;
            end
         end else begin
            if (!bus.dest_en[m_owner]) begin
               m_prev <= m_owner; m_phase <= 1;
            end else if (bus.in_valid && bus.dest_ready[m_owner]) begin
               m_log_dest.push_back(m_owner);
               m_log_cyc.push_back(m_cyc);
               if (m_beats + 1 == BURST) begin
                  m_prev <= m_owner; m_phase <= 1;
               end else begin
                  m_beats <= m_beats + 1;
               end
            end
         end
      end
   end

   logic       exp_rdy;
   logic [3:0] exp_ov;
   always_comb begin
      exp_rdy = (m_phase == 2) && bus.dest_en[m_owner[1:0]] && bus.dest_ready[m_owner[1:0]];
      exp_ov  = 4'b0000;
      if (exp_rdy && bus.in_valid) exp_ov = 4'b0001 << m_owner;
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("sel",       bus.sel,       m_owner);
      check("busy",      bus.busy,      m_phase != 0);
      check("in_ready",  bus.in_ready,  exp_rdy);
      check("out_valid", bus.out_valid, exp_ov);
      check("out_data",  bus.out_data,  bus.in_data);
   end

   task automatic step();
      @(posedge clk);
      #1;
      bus.in_data = bus.in_data + 8'd1;
   endtask

   task automatic do_reset(input logic [3:0] en, input logic [3:0] rdy, input logic v);
      reset_n = 1'b0;
      bus.dest_en = en;
      bus.dest_ready = rdy;
      bus.in_valid = v;
      repeat (2) @(posedge clk);
      #1;
      m_log_dest.delete();
      m_log_cyc.delete();
      reset_n = 1'b1;
   endtask

   task automatic wait_log(input int n, input string name);
      for (int i = 0; i < 200 && m_log_dest.size() < n; i++) step();
      check(name, m_log_dest.size() >= n, 1'b1);
   endtask

   int t2_exp[12] = '{1, 1, 1, 1, 3, 3, 3, 3, 1, 1, 1, 1};

   initial begin
      bus.in_data = 8'h00;
      bus.in_valid = 1'b0;
      bus.dest_en = 4'h0;
      bus.dest_ready = 4'h0;

      // 1: full rotation, four beats per grant, one ARB gap
      do_reset(4'hF, 4'hF, 1'b1);
      wait_log(16, "t1_wait");
      for (int i = 0; i < 16; i++) check("t1_dest", m_log_dest[i], i / 4);
      check("t1_first_cyc", m_log_cyc[0], 2);
      check("t1_gap_cyc",   m_log_cyc[4], 7);
      check("t1_last_cyc",  m_log_cyc[15], 20);

      // 2: only B and D enabled
      do_reset(4'b1010, 4'hF, 1'b1);
      wait_log(12, "t2_wait");
      for (int i = 0; i < 12; i++) check("t2_dest", m_log_dest[i], t2_exp[i]);

      // 3: stall C for three cycles after its first beat
      do_reset(4'hF, 4'hF, 1'b1);
      wait_log(9, "t3_wait_a");
      check("t3_beat1_dest", m_log_dest[8], 2);
      check("t3_beat1_cyc",  m_log_cyc[8], 12);
      bus.dest_ready = 4'b1011;
      for (int j = 0; j < 3; j++) begin
         #1;
         check("t3_stall_rdy", bus.in_ready, 1'b0);
         check("t3_stall_sel", bus.sel, 2'd2);
         step();
      end
      bus.dest_ready = 4'hF;
      wait_log(13, "t3_wait_b");
      for (int i = 9; i < 12; i++) check("t3_resume_dest", m_log_dest[i], 2);
      check("t3_resume_cyc", m_log_cyc[9], 16);
      check("t3_next_dest",  m_log_dest[12], 3);
      check("t3_next_cyc",   m_log_cyc[12], 20);

      // 4: withdraw A after its second beat
      do_reset(4'hF, 4'hF, 1'b1);
      wait_log(2, "t4_wait_a");
      bus.dest_en = 4'b1110;
      #1;
      check("t4_preempt_rdy",  bus.in_ready, 1'b0);
      check("t4_preempt_busy", bus.busy, 1'b1);
      step();
      check("t4_arb_rdy", bus.in_ready, 1'b0);
      wait_log(7, "t4_wait_b");
      check("t4_b_dest", m_log_dest[2], 1);
      check("t4_b_cyc",  m_log_cyc[2], 6);
      check("t4_b_end",  m_log_dest[5], 1);
      check("t4_c_dest", m_log_dest[6], 2);
      check("t4_c_cyc",  m_log_cyc[6], 11);

      // 5: nobody ready, then only D
      do_reset(4'hF, 4'h0, 1'b1);
      for (int j = 0; j < 4; j++) begin
         step();
         check("t5_arb_busy", bus.busy, 1'b1);
         check("t5_arb_rdy",  bus.in_ready, 1'b0);
      end
      bus.dest_ready = 4'b1000;
      step();
      check("t5_sel", bus.sel, 2'd3);
      check("t5_rdy", bus.in_ready, 1'b1);
      check("t5_ov",  bus.out_valid, 4'b1000);

      // 6: asynchronous reset in the middle of a burst
      do_reset(4'hF, 4'hF, 1'b1);
      wait_log(2, "t6_wait_a");
      #2;
      check("t6_pre_rdy", bus.in_ready, 1'b1);
      reset_n = 1'b0;
      #1;
      check("t6_rst_ov",   bus.out_valid, 4'b0000);
      check("t6_rst_rdy",  bus.in_ready, 1'b0);
      check("t6_rst_busy", bus.busy, 1'b0);
      check("t6_rst_sel",  bus.sel, 2'd0);
      do_reset(4'hF, 4'hF, 1'b1);
      wait_log(1, "t6_wait_b");
      check("t6_first_dest", m_log_dest[0], 0);
      check("t6_first_cyc",  m_log_cyc[0], 2);

      bus.in_valid = 1'b0;
      step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
